// File: rtl/instr_fetch_if.sv
// Instruction memory read bus: registered address/strobe out, data/valid back.
interface instr_fetch_if #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 24
);
    logic [ADDR_W-1:0]  mem_addr;
    logic               mem_rd_en;
    logic [INSTR_W-1:0] mem_rdata;
    logic               mem_valid;

    modport master (
        output mem_addr,
        output mem_rd_en,
        input  mem_rdata,
        input  mem_valid
    );

    modport slave (
        input  mem_addr,
        input  mem_rd_en,
        output mem_rdata,
        output mem_valid
    );
endinterface

// File: rtl/instr_fetch.sv
// Fetch stage: program counter, single-outstanding read to instruction memory,
// instruction register. All outputs are registered.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no request outstanding; waits for an IR_load rising edge
// S_WAIT  | request issued; waits for mem_valid or the wait limit
// S_FAULT | memory never answered; terminal until rst
module instr_fetch #(
    parameter int ADDR_W  = 8,
    parameter int INSTR_W = 24,
    parameter int TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [ADDR_W-1:0]  PC_load,
    input  logic               PC_en,
    input  logic               PC_inc,
    input  logic               IR_load,
    instr_fetch_if.master      mem,
    output logic [INSTR_W-1:0] command_word,
    output logic               ReadyRegFlag,
    output logic [ADDR_W-1:0]  PC_current_value,
    output logic               fetch_busy,
    output logic               fetch_fault
);

    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_FAULT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               rd_en_q, rd_en_d;
    logic [INSTR_W-1:0] cw_q, cw_d;
    logic               rdy_q, rdy_d;
    logic               busy_q, busy_d;
    logic               fault_q, fault_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ir_prev_q, inc_prev_q;
    logic               ir_rise, inc_rise;

    assign ir_rise  = IR_load & ~ir_prev_q;
    assign inc_rise = PC_inc & ~inc_prev_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            pc_q       <= '0;
            addr_q     <= '0;
            rd_en_q    <= 1'b0;
            cw_q       <= '0;
            rdy_q      <= 1'b0;
            busy_q     <= 1'b0;
            fault_q    <= 1'b0;
            cnt_q      <= '0;
            ir_prev_q  <= 1'b0;
            inc_prev_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            cw_q       <= cw_d;
            rdy_q      <= rdy_d;
            busy_q     <= busy_d;
            fault_q    <= fault_d;
            cnt_q      <= cnt_d;
            ir_prev_q  <= IR_load;
            inc_prev_q <= PC_inc;
        end
    end

    // A coincident increment edge is dropped when a load happens.
    always_comb begin
        pc_d = pc_q;
        if (PC_en) begin
            pc_d = PC_load;
        end else if (inc_rise) begin
            pc_d = pc_q + ADDR_W'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rd_en_d = 1'b0;
        cw_d    = cw_q;
        rdy_d   = rdy_q;
        busy_d  = busy_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE: begin
                if (ir_rise) begin
                    addr_d  = pc_q;
                    rd_en_d = 1'b1;
                    busy_d  = 1'b1;
                    rdy_d   = 1'b0;
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Data arriving on the last allowed cycle still beats the timeout.
                if (mem.mem_valid) begin
                    cw_d    = mem.mem_rdata;
                    rdy_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    fault_d = 1'b1;
                    busy_d  = 1'b0;
                    state_d = S_FAULT;
                end
            end
            S_FAULT: begin
                state_d = S_FAULT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign mem.mem_addr     = addr_q;
    assign mem.mem_rd_en    = rd_en_q;
    assign command_word     = cw_q;
    assign ReadyRegFlag     = rdy_q;
    assign PC_current_value = pc_q;
    assign fetch_busy       = busy_q;
    assign fetch_fault      = fault_q;

endmodule
